countdown_matrix: RTL and testbench
===================================

# countdown_matrix

Countdown timer and 8×8 bicolour dot-matrix driver for the guessing game. It sits directly under the game controller: it receives a start level, an enable and a 3-bit seconds value, and counts down once per second. It shows the remaining seconds as a red digit, or a green greeting glyph when idle. It returns an `over` level that the controller gates with the player's confirm button.

## Interface
**Parameters**
- `TICK_DIV`, default 1_000_000: clock cycles per countdown second; legal range 2 or more.
- `SCAN_DIV`, default 1_000: clock cycles per matrix row; legal range 2 or more.

**Ports**
- `clk`  in  1  system clock; the block has one clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cst`  in  1  countdown enable (level). A rising edge starts a count; low aborts it.
- `dzst`  in  1  matrix display enable (level).
- `num`  in  3  start value in seconds, 0–7, sampled on the `cst` rising edge.
- `row`  out  8  row select, active-low one-hot.
- `colr`  out  8  red columns, active-high; bit 7 is the leftmost column.
- `colg`  out  8  green columns, active-high; bit 7 is the leftmost column.
- `over`  out  1  countdown finished (level).

## Operation
**States**
- IDLE:
  - `cst` rising edge with `num` ≠ 0 → RUN. Load `remain = num` and clear the tick counter.
  - `cst` rising edge with `num` = 0 → DONE.
- RUN:
  - When the tick counter reaches `TICK_DIV-1`, it wraps to 0 and `remain` decrements.
  - A decrement from 1 to 0 → DONE.
- DONE: `over` = 1, held.
- From any state, `cst` = 0 → IDLE and clear the tick counter. `remain` is retained for display only.

**Rising-edge detect**
- Use a registered copy of `cst`, reset to 0.
- If `cst` is high when reset releases, that is not an edge: the block stays IDLE until `cst` goes low and then high again.

**Display content**
- `dzst` = 0: `row` = 8'hFF, `colr` = `colg` = 0.
- `dzst` = 1, IDLE: greeting glyph, green only.
- `dzst` = 1, RUN: digit glyph for `remain`, red only.
- `dzst` = 1, DONE: digit glyph "0", red and green (yellow).

**Row scan**
- Runs continuously out of reset, independent of `dzst`.
- The scan index advances every `SCAN_DIV` cycles and wraps 7 → 0.
- `row = ~(8'b1 << idx)`. The column bytes are the glyph row `idx`, masked per the display rules above.

**Widths**
- `remain` is 3 bits and never decrements below 0.
- The tick counter and scan counter are sized with `$clog2` of their divider.

## Timing
**Reset values:** `row` = 8'hFF, `colr` = 0, `colg` = 0, `over` = 0, state IDLE, `remain` = 0, scan index 0, both counters 0.

**Countdown timing**
- All outputs are registered.
- Edge on cycle E: RUN is entered at E+1.
- The first decrement is at E+1+`TICK_DIV`.
- `over` rises exactly `num`×`TICK_DIV`+1 cycles after E.
- With `num` = 0, `over` rises at E+1.

**Abort and restart**
- `over` falls one cycle after `cst` falls.
- `cst` dropping mid-RUN aborts with no `over` pulse.
- `cst` dropping and re-rising on back-to-back cycles restarts cleanly with a fresh `num`.

**Display update**
- Column and row outputs change together, one cycle after the scan index or the displayed content changes.
- A `dzst` change takes effect on the next cycle.

**Simultaneous events:** a tick and a `cst` fall in the same cycle give IDLE, with no decrement and no `over`.

## Structure
- Shared include `game_defs.vh` holds:
  - state encodings (IDLE = 0, RUN = 1, DONE = 2);
  - the greeting glyph;
  - the default divider constants.
- Sub-module `dz_glyph_rom`:
  - purely combinational;
  - inputs: `sel` (4 bits: 0–7 select the digits, 8 selects the greeting) and row index (3 bits);
  - output: 8-bit column byte.

## Test plan
All scenarios use `TICK_DIV` = 10 and `SCAN_DIV` = 2.

1. **Reset:** hold `rst_n` = 0 with random inputs → `row` = FF, `colr` = `colg` = 00, `over` = 0. Release → the row scan steps FE, FD, … 7F, FE, every 2 cycles.
2. **Normal count:** `num` = 3, `cst` rises at cycle E → `over` = 1 at E+31. While in RUN, the red columns match glyphs "3", "2", "1" in successive 10-cycle windows and `colg` = 0.
3. **Zero start:** `num` = 0, `cst` rises → `over` = 1 at E+1 and the display is yellow "0".
4. **Abort:** `num` = 5, drop `cst` at E+23 → `over` never asserts, state is IDLE at E+24, and the green greeting is shown. Re-raise `cst` with `num` = 1 → `over` 11 cycles after the new edge.
5. **Display gating:** `dzst` = 0 during RUN → `row` = FF and the columns are 0 from the next cycle, while the countdown still completes on schedule.
6. **Mid-operation reset:** assert `rst_n` = 0 during RUN → outputs go to reset values immediately. Release with `cst` held high → no restart until `cst` toggles low then high.

Source files
------------

// File: rtl/countdown_matrix_pkg.sv
// rtl/countdown_matrix_pkg.sv - shared types, glyph data and defaults for the countdown matrix
// Contents:
//   state_t          countdown FSM states (IDLE = 0, RUN = 1, DONE = 2)
//   GREET_GLYPH      8x8 idle greeting, row 0 in bits [63:56], bit 7 = leftmost column
//   SEL_GREET        glyph ROM select code for the greeting
//   DEF_TICK_DIV     default clock cycles per countdown second
//   DEF_SCAN_DIV     default clock cycles per matrix row
//   glyph_row()      extracts one row byte from a packed 64-bit glyph
package countdown_matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [63:0] GREET_GLYPH  = 64'h3C42_A581_A599_423C;
  localparam logic [3:0]  SEL_GREET    = 4'd8;
  localparam int          DEF_TICK_DIV = 1_000_000;
  localparam int          DEF_SCAN_DIV = 1_000;

  // Row 0 is the top row and sits in the most significant byte.
  function automatic logic [7:0] glyph_row(input logic [63:0] glyph, input logic [2:0] idx);
    logic [63:0] shifted;
    shifted = glyph >> {3'd7 - idx, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/countdown_matrix_glyph_rom.sv
// rtl/countdown_matrix_glyph_rom.sv - combinational 8x8 glyph ROM (digits 0-7 and greeting)
// Ports:
//   sel      in  4  glyph select: 0-7 digits, 8 greeting, others blank
//   row_idx  in  3  glyph row, 0 = top
//   cols     out 8  column byte for that row, bit 7 = leftmost column
module dz_glyph_rom
  import countdown_matrix_pkg::*;
(
  input  logic [3:0] sel,
  input  logic [2:0] row_idx,
  output logic [7:0] cols
);

  logic [63:0] glyph;

  always_comb begin
    glyph = '0;
    case (sel)
      4'd0:    glyph = 64'h3C66_6E76_6666_3C00;
      4'd1:    glyph = 64'h1838_1818_1818_7E00;
      4'd2:    glyph = 64'h3C66_060C_3060_7E00;
      4'd3:    glyph = 64'h3C66_061C_0666_3C00;
      4'd4:    glyph = 64'h0C1C_3C6C_7E0C_0C00;
      4'd5:    glyph = 64'h7E60_7C06_0666_3C00;
      4'd6:    glyph = 64'h3C60_7C66_6666_3C00;
      4'd7:    glyph = 64'h7E06_0C18_3030_3000;
      SEL_GREET: glyph = GREET_GLYPH;
      default: glyph = '0;
    endcase
    cols = glyph_row(glyph, row_idx);
  end

endmodule

// File: rtl/countdown_matrix.sv
// rtl/countdown_matrix.sv - countdown timer with 8x8 bicolour dot-matrix driver
// Parameters:
//   TICK_DIV  clock cycles per countdown second (>= 2)
//   SCAN_DIV  clock cycles per matrix row (>= 2)
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   cst    in  1  countdown enable level; rising edge starts, low aborts
//   dzst   in  1  matrix display enable
//   num    in  3  start seconds, sampled on the cst rising edge
//   row    out 8  row select, active-low one-hot
//   colr   out 8  red columns, active-high, bit 7 leftmost
//   colg   out 8  green columns, active-high, bit 7 leftmost
//   over   out 1  countdown finished level
module countdown_matrix
  import countdown_matrix_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cst,
  input  logic       dzst,
  input  logic [2:0] num,
  output logic [7:0] row,
  output logic [7:0] colr,
  output logic [7:0] colg,
  output logic       over
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  state_t          state;
  logic [2:0]      remain;
  logic [TW-1:0]   tick;
  logic            cst_q;
  logic            armed;
  logic            cst_rise;
  logic [SW-1:0]   scan_cnt;
  logic [2:0]      idx;
  logic [3:0]      sel;
  logic [7:0]      glyph_cols;

  // armed stays low until cst has been seen low after reset, so a cst
  // already high at reset release is not mistaken for a start edge.
  assign cst_rise = cst & ~cst_q & armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      remain <= '0;
      tick   <= '0;
      cst_q  <= 1'b0;
      armed  <= 1'b0;
      over   <= 1'b0;
    end else begin
      cst_q <= cst;
      if (!cst) begin
        armed <= 1'b1;
      end
      // A low cst wins over a same-cycle tick: abort without decrementing.
      if (!cst) begin
        state <= ST_IDLE;
        tick  <= '0;
        over  <= 1'b0;
      end else if (cst_rise) begin
        tick   <= '0;
        remain <= num;
        if (num == 3'd0) begin
          state <= ST_DONE;
          over  <= 1'b1;
        end else begin
          state <= ST_RUN;
          over  <= 1'b0;
        end
      end else if (state == ST_RUN) begin
        if (tick == TICK_LAST) begin
          tick <= '0;
          if (remain != 3'd0) begin
            remain <= remain - 3'd1;
          end
          if (remain == 3'd1) begin
            state <= ST_DONE;
            over  <= 1'b1;
          end
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

  // Row scan free-runs regardless of dzst so the refresh cadence never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    sel = 4'd0;
    case (state)
      ST_IDLE: sel = SEL_GREET;
      ST_RUN:  sel = {1'b0, remain};
      default: sel = 4'd0;
    endcase
  end

  dz_glyph_rom u_rom (
    .sel     (sel),
    .row_idx (idx),
    .cols    (glyph_cols)
  );

  // IDLE is green only, RUN red only, DONE both (yellow).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= 8'hFF;
      colr <= 8'h00;
      colg <= 8'h00;
    end else if (!dzst) begin
      row  <= 8'hFF;
      colr <= 8'h00;
      colg <= 8'h00;
    end else begin
      row  <= ~(8'h01 << idx);
      colr <= (state != ST_IDLE) ? glyph_cols : 8'h00;
      colg <= (state != ST_RUN)  ? glyph_cols : 8'h00;
    end
  end

endmodule

// File: tb/tb_countdown_matrix.sv
// tb/tb_countdown_matrix.sv - self-checking bench for countdown_matrix
module tb_countdown_matrix;

  localparam int T = 10;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cst = 1'b0;
  logic       dzst = 1'b0;
  logic [2:0] num = 3'd0;
  logic [7:0] row, colr, colg;
  logic       over;

  always #5 clk = ~clk;

  countdown_matrix #(.TICK_DIV(T), .SCAN_DIV(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cst   (cst),
    .dzst  (dzst),
    .num   (num),
    .row   (row),
    .colr  (colr),
    .colg  (colg),
    .over  (over)
  );

  logic [7:0] font [0:7][0:7] = '{
    '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
    '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00}
  };
  logic [7:0] smile [0:7] = '{8'h3C, 8'h42, 8'hA5, 8'h81, 8'hA5, 8'h99, 8'h42, 8'h3C};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 counting, 2 finished; remaining time is
  // derived from the start edge number rather than tracked per cycle.
  int         cyc_since;
  int         mode;
  int         m_e;
  int         m_num;
  bit         armed;
  bit         cst_prev;
  logic [7:0] e_row, e_colr, e_colg;
  logic       e_over;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("row", row, e_row);
    check("colr", colr, e_colr);
    check("colg", colg, e_colg);
    check("over", {7'b0, over}, {7'b0, e_over});
  endtask

  task automatic model_reset();
    mode      = 0;
    m_e       = 0;
    m_num     = 0;
    armed     = 1'b0;
    cst_prev  = 1'b0;
    cyc_since = 0;
    e_row     = 8'hFF;
    e_colr    = 8'h00;
    e_colg    = 8'h00;
    e_over    = 1'b0;
  endtask

  task automatic step();
    int idx_prev;
    int rem_prev;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      cyc_since++;
      idx_prev = ((cyc_since - 1) / S) % 8;
      rem_prev = m_num - (cyc_since - 1 - m_e) / T;
      if (!dzst) begin
        e_row  = 8'hFF;
        e_colr = 8'h00;
        e_colg = 8'h00;
      end else begin
        e_row = ~(8'h01 << idx_prev);
        case (mode)
          0: begin e_colr = 8'h00; e_colg = smile[idx_prev]; end
          1: begin e_colr = font[rem_prev][idx_prev]; e_colg = 8'h00; end
          default: begin e_colr = font[0][idx_prev]; e_colg = font[0][idx_prev]; end
        endcase
      end
      if (!cst) begin
        mode = 0;
      end else if (!cst_prev && armed) begin
        m_e   = cyc_since;
        m_num = int'(num);
        mode  = (num == 3'd0) ? 2 : 1;
      end else if (mode == 1 && (cyc_since - m_e) / T >= m_num) begin
        mode = 2;
      end
      if (!cst) armed = 1'b1;
      cst_prev = cst;
      e_over   = (mode == 2);
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int nn;
    model_reset();

    // Reset held with random inputs
    repeat (6) begin
      cst  = 1'($urandom);
      dzst = 1'($urandom);
      num  = 3'($urandom);
      step();
    end
    cst = 1'b0; dzst = 1'b1; num = 3'd0;
    rst_n = 1'b1;
    repeat (20) step();

    // Normal count from 3
    num = 3'd3; cst = 1'b1;
    repeat (40) step();

    // Zero start
    cst = 1'b0; step();
    num = 3'd0; cst = 1'b1;
    repeat (6) step();

    // Abort mid-run, then restart with 1
    cst = 1'b0; step();
    num = 3'd5; cst = 1'b1;
    repeat (23) step();
    cst = 1'b0;
    repeat (3) step();
    num = 3'd1; cst = 1'b1;
    repeat (15) step();

    // Back-to-back drop and re-rise with a fresh num
    cst = 1'b0; step();
    num = 3'd2; cst = 1'b1;
    repeat (25) step();

    // Display gating while counting
    cst = 1'b0; step();
    num = 3'($urandom_range(1, 7)); cst = 1'b1;
    nn = int'(num) * T + 5;
    for (int i = 0; i < nn; i++) begin
      dzst = 1'($urandom);
      step();
    end
    dzst = 1'b1;

    // Mid-run reset, release with cst still high
    cst = 1'b0; step();
    num = 3'd4; cst = 1'b1;
    repeat (15) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    num = 3'($urandom);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    cst = 1'b0; step();
    num = 3'd2; cst = 1'b1;
    repeat (25) step();

    // Randomized sessions
    repeat (12) begin
      num  = 3'($urandom);
      cst  = 1'b1;
      dzst = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(1, 80)) step();
      cst = 1'b0;
      repeat ($urandom_range(1, 3)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
